// File: rtl/ab_pattern_gen.sv
`default_nettype none
// ============================================================================
// ab_pattern_gen : loads 2-bit A/B symbols, then replays them one per cycle
//                  while counting Q=1 responses (saturating).       Rev 1.0
// ============================================================================
module ab_pattern_gen #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  input  logic       start,
  input  logic       Q,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic [3:0] q_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_buf [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] w_rd_next;
  logic [CW-1:0] r_count;
  logic [3:0]    r_q_count;
  logic          r_a;
  logic          r_b;
  logic          w_accept;
  logic          w_launch;
  logic          w_last;
  logic [1:0]    w_first_sym;

  assign w_rd_next = r_rd_ptr + PW'(1);
  assign A         = r_a;
  assign B         = r_b;
  assign q_count   = r_q_count;

  always_comb begin
    w_next      = r_state;
    sym_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    w_accept    = 1'b0;
    w_launch    = 1'b0;
    w_last      = (CW'(r_rd_ptr) == (r_count - CW'(1)));
    // An empty buffer can only launch if this edge writes slot 0.
    w_first_sym = (r_count == '0) ? sym_in : r_buf[0];
    case (r_state)
      S_IDLE: begin
        sym_ready = (r_count < CW'(DEPTH));
        w_accept  = sym_valid && sym_ready;
        if (start && ((r_count != '0) || w_accept)) begin
          w_launch = 1'b1;
          w_next   = S_PLAY;
        end
      end
      S_PLAY: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= 2'b00;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_q_count <= 4'd0;
      r_a       <= 1'b0;
      r_b       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_buf[r_wr_ptr] <= sym_in;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
        r_count         <= r_count + CW'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_q_count  <= 4'd0;
            r_rd_ptr   <= '0;
            {r_a, r_b} <= w_first_sym;
          end
        end
        S_PLAY: begin
          if (Q && (r_q_count != 4'hF)) r_q_count <= r_q_count + 4'd1;
          if (w_last) begin
            {r_a, r_b} <= 2'b00;
          end else begin
            r_rd_ptr   <= w_rd_next;
            {r_a, r_b} <= r_buf[w_rd_next];
          end
        end
        S_DONE: begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire
